// File: rtl/pio_in_debounce_pkg.sv
// Shared constants for the debounced parallel input port: register map,
// edge-capture mode codes, bus request struct and a counter sizing helper.
package pio_pkg;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd1;
  localparam logic [1:0] ADDR_EDGE = 2'd2;
  localparam logic [1:0] ADDR_RAW  = 2'd3;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  typedef struct packed {
    logic        wr;
    logic [1:0]  addr;
    logic [31:0] data;
  } pio_req_t;

  // One spare bit above clog2 so DB_CYCLES-1 always fits, even for DB_CYCLES=1.
  function automatic int cnt_width(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/pio_in_debounce_if.sv
// Slave bus of the debounced input port: register access plus level interrupt.
interface pio_in_debounce_if;
  logic        chipselect;
  logic [1:0]  address;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (output chipselect, address, write_n, writedata,
                  input  readdata, irq);
  modport slave  (input  chipselect, address, write_n, writedata,
                  output readdata, irq);
endinterface

// File: rtl/pio_in_debounce_bit.sv
// One input bit: 2-flop synchronizer, stability counter and edge detector.
module pio_debounce_bit
  import pio_pkg::*;
#(
  parameter int DB_CYCLES = 16,
  parameter int EDGE_MODE = EDGE_RISE
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pin,
  output logic raw,
  output logic level,
  output logic edge_pulse
);
  localparam int CW = cnt_width(DB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic          sync1;
  logic [CW-1:0] cnt;
  logic          accept;

  // Accept on the DB_CYCLES-th consecutive cycle the synced bit disagrees.
  assign accept = (raw != level) && (cnt == CNT_LAST);

  // level still holds the old value here, so a rising edge sees level==0.
  assign edge_pulse = accept &&
                      ((EDGE_MODE == EDGE_ANY) ||
                       ((EDGE_MODE == EDGE_RISE) ? !level : level));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= 1'b0;
      raw   <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
    end else begin
      sync1 <= pin;
      raw   <= sync1;
      if (raw == level) begin
        cnt <= '0;
      end else if (accept) begin
        level <= ~level;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/pio_in_debounce.sv
// Debounced parallel input port with edge capture, interrupt mask and a
// registered 4-word register file on a simple chipselect/write_n bus.
module pio_in_debounce
  import pio_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DB_CYCLES = 16,
  parameter int EDGE_MODE = EDGE_RISE
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_port,
  pio_in_debounce_if.slave bus
);
  logic [WIDTH-1:0] raw, data, edge_set;
  logic [WIDTH-1:0] irq_mask, edge_capture, edge_clr;
  logic [31:0]      rd_mux, readdata_q;
  pio_req_t         req;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    pio_debounce_bit #(
      .DB_CYCLES (DB_CYCLES),
      .EDGE_MODE (EDGE_MODE)
    ) u_bit (
      .clk        (clk),
      .reset_n    (reset_n),
      .pin        (in_port[i]),
      .raw        (raw[i]),
      .level      (data[i]),
      .edge_pulse (edge_set[i])
    );
  end

  if (WIDTH < 32) begin : g_unused
    logic unused_hi;
    assign unused_hi = ^bus.writedata[31:WIDTH];
  end

  assign req.wr   = bus.chipselect & ~bus.write_n;
  assign req.addr = bus.address;
  assign req.data = bus.writedata;

  assign edge_clr = (req.wr && req.addr == ADDR_EDGE) ? req.data[WIDTH-1:0] : '0;

  always_comb begin
    rd_mux = '0;
    case (req.addr)
      ADDR_DATA: rd_mux[WIDTH-1:0] = data;
      ADDR_MASK: rd_mux[WIDTH-1:0] = irq_mask;
      ADDR_EDGE: rd_mux[WIDTH-1:0] = edge_capture;
      default:   rd_mux[WIDTH-1:0] = raw;
    endcase
  end

  // A new edge wins over a write-1 clear landing in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_mask     <= '0;
      edge_capture <= '0;
      readdata_q   <= '0;
    end else begin
      if (req.wr && req.addr == ADDR_MASK) irq_mask <= req.data[WIDTH-1:0];
      edge_capture <= (edge_capture & ~edge_clr) | edge_set;
      readdata_q   <= bus.chipselect ? rd_mux : '0;
    end
  end

  assign bus.readdata = readdata_q;
  assign bus.irq      = |(edge_capture & irq_mask);
endmodule
